// File: rtl/wb_queue.sv
// wb_queue: in-order write-back FIFO to the register file with forwarding; WBQ_DROP_COUNT_EN enables drop_count
module wb_queue #(
    parameter int DEPTH = 4,
    parameter int DW    = 10,
    parameter int AW    = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [AW-1:0]           in_addr,
    input  logic [DW-1:0]           in_data,
    input  logic                    rf_stall,
    output logic                    rf_we,
    output logic [AW-1:0]           rf_waddr,
    output logic [DW-1:0]           rf_wdata,
    input  logic [AW-1:0]           fwd_addr,
    output logic                    fwd_hit,
    output logic [DW-1:0]           fwd_data,
    output logic [$clog2(DEPTH):0]  count,
    output logic [7:0]              drop_count
);
    localparam int PW = $clog2(DEPTH);
    logic [AW-1:0] addr_q [DEPTH];
    logic [DW-1:0] data_q [DEPTH];
    logic [PW-1:0] head, tail;
    logic          accept, drop, push, pop;
    assign in_ready = rst && (count < (PW+1)'(DEPTH));
    assign accept   = in_valid && in_ready;
    assign drop     = accept && (in_addr >= AW'(4));
    assign push     = accept && !drop;
    assign rf_we    = (count != '0) && !rf_stall;
    assign pop      = rf_we;
    assign rf_waddr = (count != '0) ? addr_q[head] : '0;
    assign rf_wdata = (count != '0) ? data_q[head] : '0;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + PW'(1);
            if (pop) head <= head + PW'(1);
            count <= count + (PW+1)'(push) - (PW+1)'(pop);
        end
    end
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[tail] <= in_addr;
            data_q[tail] <= in_data;
        end
    end
    // walk oldest to youngest so the youngest match wins
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((PW+1)'(i) < count && addr_q[head + PW'(i)] == fwd_addr) begin
                fwd_hit  = 1'b1;
                fwd_data = data_q[head + PW'(i)];
            end
        end
    end
`ifdef WBQ_DROP_COUNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) drop_count <= '0;
        else if (drop && drop_count != 8'hff) drop_count <= drop_count + 8'd1;
    end
`else
    assign drop_count = '0;
`endif
endmodule

// File: tb/tb_wb_queue.sv
// tb_wb_queue: directed self-checking bench for wb_queue
module tb_wb_queue;
    logic       clk = 0, rst = 0, in_valid = 0, rf_stall = 0;
    logic       in_ready, rf_we, fwd_hit;
    logic [2:0] in_addr = 0, rf_waddr, fwd_addr = 0;
    logic [9:0] in_data = 0, rf_wdata, fwd_data;
    logic [2:0] count;
    logic [7:0] drop_count;
    int errors = 0, checks = 0;
`ifdef WBQ_DROP_COUNT_EN
    localparam bit DC = 1'b1;
`else
    localparam bit DC = 1'b0;
`endif

    wb_queue dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_addr(in_addr), .in_data(in_data), .rf_stall(rf_stall),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .fwd_addr(fwd_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
        .count(count), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #3;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %0d exp 0", in_ready); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL reset_rf_we got %0d exp 0", rf_we); end
        checks++; if (fwd_hit !== 1'b0 || fwd_data !== 10'd0) begin errors++; $display("FAIL reset_fwd got %0d/%0d exp 0/0", fwd_hit, fwd_data); end
        checks++; if (drop_count !== 8'd0) begin errors++; $display("FAIL reset_drop got %0d exp 0", drop_count); end
        @(negedge clk);
        rst = 1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready got %0d exp 1", in_ready); end
        step();
    endtask

    task automatic test_single();
        rf_stall = 0; in_valid = 1; in_addr = 1; in_data = 55;
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL single_no_bypass got %0d exp 0", rf_we); end
        step();
        in_valid = 0;
        checks++; if (rf_we !== 1'b1 || rf_waddr !== 3'd1 || rf_wdata !== 10'd55) begin errors++; $display("FAIL single_out got we=%0d a=%0d d=%0d exp 1/1/55", rf_we, rf_waddr, rf_wdata); end
        step();
        checks++; if (rf_we !== 1'b0 || count !== 3'd0) begin errors++; $display("FAIL single_after got we=%0d cnt=%0d exp 0/0", rf_we, count); end
        checks++; if (rf_waddr !== 3'd0 || rf_wdata !== 10'd0) begin errors++; $display("FAIL single_empty_out got %0d/%0d exp 0/0", rf_waddr, rf_wdata); end
    endtask

    task automatic test_fill();
        rf_stall = 1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1; in_addr = 3'(i); in_data = 10'(i + 1);
            step();
        end
        in_valid = 0;
        checks++; if (count !== 3'd4 || in_ready !== 1'b0) begin errors++; $display("FAIL fill_full got cnt=%0d rdy=%0d exp 4/0", count, in_ready); end
        rf_stall = 0;
        #1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (rf_we !== 1'b1 || rf_waddr !== 3'(i) || rf_wdata !== 10'(i + 1)) begin errors++; $display("FAIL fill_drain%0d got we=%0d a=%0d d=%0d exp 1/%0d/%0d", i, rf_we, rf_waddr, rf_wdata, i, i + 1); end
            step();
        end
        checks++; if (count !== 3'd0 || in_ready !== 1'b1 || rf_we !== 1'b0) begin errors++; $display("FAIL fill_empty got cnt=%0d rdy=%0d we=%0d exp 0/1/0", count, in_ready, rf_we); end
    endtask

    task automatic test_drop();
        in_valid = 1; in_addr = 4; in_data = 100;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL drop_ready got %0d exp 1", in_ready); end
        step();
        in_valid = 0;
        checks++; if (rf_we !== 1'b0 || count !== 3'd0) begin errors++; $display("FAIL drop_not_stored got we=%0d cnt=%0d exp 0/0", rf_we, count); end
        checks++; if (drop_count !== (DC ? 8'd1 : 8'd0)) begin errors++; $display("FAIL drop_one got %0d exp %0d", drop_count, DC ? 1 : 0); end
        in_valid = 1; in_addr = 7;
        repeat (300) step();
        in_valid = 0;
        checks++; if (drop_count !== (DC ? 8'd255 : 8'd0)) begin errors++; $display("FAIL drop_sat got %0d exp %0d", drop_count, DC ? 255 : 0); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL drop_count_q got %0d exp 0", count); end
    endtask

    task automatic test_forward();
        rf_stall = 1; fwd_addr = 2;
        in_valid = 1; in_addr = 2; in_data = 7; step();
        in_addr = 2; in_data = 9; step();
        in_valid = 0;
        checks++; if (fwd_hit !== 1'b1 || fwd_data !== 10'd9) begin errors++; $display("FAIL fwd_youngest got %0d/%0d exp 1/9", fwd_hit, fwd_data); end
        in_valid = 1; in_addr = 2; in_data = 11;
        #1;
        checks++; if (fwd_data !== 10'd9) begin errors++; $display("FAIL fwd_excl_offer got %0d exp 9", fwd_data); end
        in_valid = 0; fwd_addr = 5;
        #1;
        checks++; if (fwd_hit !== 1'b0 || fwd_data !== 10'd0) begin errors++; $display("FAIL fwd_miss got %0d/%0d exp 0/0", fwd_hit, fwd_data); end
        fwd_addr = 2; rf_stall = 0;
        step();
        checks++; if (rf_we !== 1'b1 || fwd_hit !== 1'b1 || fwd_data !== 10'd9) begin errors++; $display("FAIL fwd_popping got we=%0d hit=%0d d=%0d exp 1/1/9", rf_we, fwd_hit, fwd_data); end
        step();
        checks++; if (count !== 3'd0 || fwd_hit !== 1'b0) begin errors++; $display("FAIL fwd_drained got cnt=%0d hit=%0d exp 0/0", count, fwd_hit); end
    endtask

    task automatic test_back_to_back();
        logic [2:0] qa[$];
        logic [9:0] qd[$];
        rf_stall = 1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1; in_addr = 3'(i); in_data = 10'(20 + i);
            qa.push_back(3'(i)); qd.push_back(10'(20 + i));
            step();
        end
        rf_stall = 0;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1; in_addr = (i == 0) ? 3'd3 : 3'(i % 4); in_data = (i == 0) ? 10'd200 : 10'(30 + i);
            #1;
            checks++; if (rf_we !== 1'b1 || rf_waddr !== qa[0] || rf_wdata !== qd[0]) begin errors++; $display("FAIL b2b_out%0d got we=%0d a=%0d d=%0d exp 1/%0d/%0d", i, rf_we, rf_waddr, rf_wdata, qa[0], qd[0]); end
            void'(qa.pop_front()); void'(qd.pop_front());
            qa.push_back(in_addr); qd.push_back(in_data);
            step();
            checks++; if (count !== 3'd3) begin errors++; $display("FAIL b2b_count%0d got %0d exp 3", i, count); end
        end
        in_valid = 0;
        for (int i = 0; i < 3; i++) begin
            checks++; if (rf_we !== 1'b1 || rf_waddr !== qa[0] || rf_wdata !== qd[0]) begin errors++; $display("FAIL b2b_tail%0d got we=%0d a=%0d d=%0d exp 1/%0d/%0d", i, rf_we, rf_waddr, rf_wdata, qa[0], qd[0]); end
            void'(qa.pop_front()); void'(qd.pop_front());
            step();
        end
        checks++; if (count !== 3'd0 || rf_we !== 1'b0) begin errors++; $display("FAIL b2b_empty got cnt=%0d we=%0d exp 0/0", count, rf_we); end
    endtask

    task automatic test_reset_mid();
        rf_stall = 1;
        in_valid = 1; in_addr = 1; in_data = 5; step();
        in_addr = 2; in_data = 6; step();
        in_valid = 0; rf_stall = 0;
        #1;
        checks++; if (rf_we !== 1'b1 || rf_waddr !== 3'd1 || count !== 3'd2) begin errors++; $display("FAIL mid_pre got we=%0d a=%0d cnt=%0d exp 1/1/2", rf_we, rf_waddr, count); end
        rst = 0;
        #1;
        checks++; if (rf_we !== 1'b0 || count !== 3'd0 || in_ready !== 1'b0) begin errors++; $display("FAIL mid_async got we=%0d cnt=%0d rdy=%0d exp 0/0/0", rf_we, count, in_ready); end
        checks++; if (rf_waddr !== 3'd0 || rf_wdata !== 10'd0 || fwd_data !== 10'd0) begin errors++; $display("FAIL mid_outs got a=%0d d=%0d f=%0d exp 0/0/0", rf_waddr, rf_wdata, fwd_data); end
        #2;
        rst = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (rf_we !== 1'b0 || count !== 3'd0) begin errors++; $display("FAIL mid_stale%0d got we=%0d cnt=%0d exp 0/0", i, rf_we, count); end
        end
        in_valid = 1; in_addr = 3; in_data = 8; step();
        in_valid = 0;
        checks++; if (rf_we !== 1'b1 || rf_waddr !== 3'd3 || rf_wdata !== 10'd8) begin errors++; $display("FAIL mid_resume got we=%0d a=%0d d=%0d exp 1/3/8", rf_we, rf_waddr, rf_wdata); end
        step();
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL mid_final got %0d exp 0", count); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_drop();
        test_forward();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
